axis_gap_ctrl: RTL and testbench
================================

AXIS_GAP_CTRL -- requirements
Module: axis_gap_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent AXIS channels gated.
REQ-002 SHALL have parameter DELAY_WIDTH, default 9, gap counter width per channel.
REQ-003 SHALL have parameter PKT_WIDTH, default 4, packets-per-gap counter width.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port s_tvalid  input  NUM_CH  valid from upstream master, one bit per channel.
REQ-007 SHALL have port s_tlast  input  NUM_CH  last from upstream master.
REQ-008 SHALL have port s_tready  output  NUM_CH  ready to upstream master.
REQ-009 SHALL have port m_tvalid  output  NUM_CH  valid to downstream slave.
REQ-010 SHALL have port m_tready  input  NUM_CH  ready from downstream slave.
REQ-011 SHALL have port enable  input  NUM_CH  per-channel enable.
REQ-012 SHALL have port mode  input  NUM_CH  1 = trigger on ready falling edge, 0 = trigger on accepted tlast beat.
REQ-013 SHALL have port delay  input  NUM_CH*DELAY_WIDTH  per-channel gap length in cycles, channel i at bits [i*DELAY_WIDTH +: DELAY_WIDTH].
REQ-014 SHALL have port pkt_per_gap  input  NUM_CH*PKT_WIDTH  packets between gaps, channel i at [i*PKT_WIDTH +: PKT_WIDTH].
REQ-015 SHALL have port active  output  NUM_CH  asserted while channel is in GAP.

Function
REQ-016 Per channel, open = (state != GAP); s_tready = m_tready & open; m_tvalid = s_tvalid & open; purely combinational, zero latency.
REQ-017 Channel FSM states: IDLE (no packet in flight), PKT (beat accepted, tlast not yet seen), GAP (gate closed, counter > 0).
REQ-018 Beat accepted = s_tvalid & s_tready; IDLE->PKT on accepted beat without tlast; PKT->IDLE on accepted beat with tlast unless a gap triggers.
REQ-019 Mode 0: each accepted tlast beat increments pkt_cnt; when pkt_cnt+1 reaches effective N (pkt_per_gap, value 0 treated as 1), next state GAP, gap_cnt loaded with delay, pkt_cnt cleared.
REQ-020 Mode 1: trigger when registered m_tready was 1 and current m_tready is 0 (any state); next state GAP, gap_cnt loaded with delay; pkt_per_gap ignored.
REQ-021 delay and pkt_per_gap sampled only at trigger cycle; changes during GAP do not affect current gap.
REQ-022 delay = 0 at trigger: no GAP entry; channel goes to IDLE, gate never closes.
REQ-023 GAP: gap_cnt decrements each cycle; gate closed for exactly delay cycles starting the cycle after trigger; GAP->IDLE when gap_cnt = 1.
REQ-024 Triggers occurring during GAP ignored; no re-arm, no counter reload.
REQ-025 mode change takes effect on the next trigger evaluation; a mode 1 gap entered mid-packet returns to IDLE, pkt_cnt unchanged.
REQ-026 enable low: state IDLE, gap_cnt and pkt_cnt cleared next cycle, gate open, active low; enable dropping mid-GAP aborts gap.
REQ-027 Channels fully independent; simultaneous triggers on all channels handled in the same cycle.
REQ-028 pkt_cnt is PKT_WIDTH bits, compared with equality; never wraps because cleared at N.

Reset
REQ-029 reset high at clock edge: all states IDLE, gap_cnt = 0, pkt_cnt = 0, registered m_tready = 0; overrides enable and trigger.
REQ-030 During and after reset: active = 0, gate open (s_tready = m_tready, m_tvalid = s_tvalid).
REQ-031 Reset mid-GAP: gate reopens the cycle after the reset edge.

Structure
REQ-032 Package axis_gap_pkg holds FSM state encoding (IDLE, PKT, GAP) and default parameter constants.
REQ-033 One sub-module axis_gap_ch implements a single channel; top instantiates NUM_CH copies via generate and slices packed vectors.

Verification
REQ-034 Mode 0, delay=5, N=1, 2-beat packet fully ready: m_tvalid/s_tready low exactly 5 cycles after tlast beat, active high 5 cycles.
REQ-035 Mode 0, delay=3, N=3, four 1-beat packets back-to-back: gap only after 3rd packet, 4th accepted 3 cycles later.
REQ-036 Mode 1, delay=4, m_tready 1->0 mid-packet: gate closed 4 cycles, second ready fall during gap produces no extension.
REQ-037 delay=0 any mode with triggers: active never asserts, gating transparent.
REQ-038 Channel 0 in GAP, enable[0] dropped: gate open next cycle; channel 1 gap unaffected.
REQ-039 reset pulsed mid-GAP with delay=200: active low and gate open the cycle after reset; pkt_cnt restarts from 0.

Source files
------------

// File: rtl/axis_gap_pkg.sv
// Shared state encoding and default sizing for the AXIS inter-packet gap controller.
package axis_gap_pkg;

    localparam int unsigned DEF_NUM_CH      = 4;
    localparam int unsigned DEF_DELAY_WIDTH = 9;
    localparam int unsigned DEF_PKT_WIDTH   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_GAP  = 2'd2
    } gap_state_e;

endpackage

// File: rtl/axis_gap_ch.sv
// Single-channel AXIS gap gate: closes the stream for a programmed number of
// cycles after every Nth packet (mode 0) or after a downstream ready drop (mode 1).
module axis_gap_ch
    import axis_gap_pkg::*;
#(
    parameter int unsigned DELAY_WIDTH = DEF_DELAY_WIDTH,
    parameter int unsigned PKT_WIDTH   = DEF_PKT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_tvalid,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    input  logic                   enable,
    input  logic                   mode,
    input  logic [DELAY_WIDTH-1:0] delay,
    input  logic [PKT_WIDTH-1:0]   pkt_per_gap,
    output logic                   active
);

    gap_state_e             state, state_nxt;
    logic [DELAY_WIDTH-1:0] gap_cnt, gap_cnt_nxt;
    logic [PKT_WIDTH-1:0]   pkt_cnt, pkt_cnt_nxt;
    logic                   rdy_q;

    logic                   gate_open_c;
    logic                   beat_c;
    logic                   trig_c;
    logic [PKT_WIDTH-1:0]   n_eff_c;
    logic [PKT_WIDTH-1:0]   pkt_cnt_inc_c;

    // The gate itself is combinational so an open channel adds no latency.
    assign gate_open_c   = (state != ST_GAP);
    assign s_tready      = m_tready & gate_open_c;
    assign m_tvalid      = s_tvalid & gate_open_c;
    assign active        = (state == ST_GAP);
    assign beat_c        = s_tvalid & s_tready;
    assign n_eff_c       = (pkt_per_gap == '0) ? PKT_WIDTH'(1) : pkt_per_gap;
    assign pkt_cnt_inc_c = PKT_WIDTH'(pkt_cnt + PKT_WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
            pkt_cnt <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_cnt_nxt;
            pkt_cnt <= pkt_cnt_nxt;
            rdy_q   <= m_tready;
        end
    end

    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        pkt_cnt_nxt = pkt_cnt;
        trig_c      = 1'b0;
        if (!enable) begin
            state_nxt   = ST_IDLE;
            gap_cnt_nxt = '0;
            pkt_cnt_nxt = '0;
        end else if (state == ST_GAP) begin
            // Triggers are ignored here; the running gap is never extended.
            if (gap_cnt <= DELAY_WIDTH'(1)) begin
                state_nxt   = ST_IDLE;
                gap_cnt_nxt = '0;
            end else begin
                gap_cnt_nxt = gap_cnt - DELAY_WIDTH'(1);
            end
        end else begin
            if (mode) begin
                trig_c = rdy_q & ~m_tready;
            end else if (beat_c && s_tlast) begin
                if (pkt_cnt_inc_c == n_eff_c) begin
                    trig_c      = 1'b1;
                    pkt_cnt_nxt = '0;
                end else begin
                    pkt_cnt_nxt = pkt_cnt_inc_c;
                end
            end
            // A zero-length gap degenerates to a plain return to IDLE.
            if (trig_c) begin
                if (delay != '0) begin
                    state_nxt   = ST_GAP;
                    gap_cnt_nxt = delay;
                end else begin
                    state_nxt   = ST_IDLE;
                end
            end else if (beat_c) begin
                state_nxt = s_tlast ? ST_IDLE : ST_PKT;
            end
        end
    end

endmodule

// File: rtl/axis_gap_ctrl.sv
// Multi-channel AXIS gap controller: NUM_CH independent gap gates sharing one clock.
module axis_gap_ctrl
    import axis_gap_pkg::*;
#(
    parameter int unsigned NUM_CH      = DEF_NUM_CH,
    parameter int unsigned DELAY_WIDTH = DEF_DELAY_WIDTH,
    parameter int unsigned PKT_WIDTH   = DEF_PKT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             s_tvalid,
    input  logic [NUM_CH-1:0]             s_tlast,
    output logic [NUM_CH-1:0]             s_tready,
    output logic [NUM_CH-1:0]             m_tvalid,
    input  logic [NUM_CH-1:0]             m_tready,
    input  logic [NUM_CH-1:0]             enable,
    input  logic [NUM_CH-1:0]             mode,
    input  logic [NUM_CH*DELAY_WIDTH-1:0] delay,
    input  logic [NUM_CH*PKT_WIDTH-1:0]   pkt_per_gap,
    output logic [NUM_CH-1:0]             active
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        axis_gap_ch #(
            .DELAY_WIDTH (DELAY_WIDTH),
            .PKT_WIDTH   (PKT_WIDTH)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .s_tvalid    (s_tvalid[i]),
            .s_tlast     (s_tlast[i]),
            .s_tready    (s_tready[i]),
            .m_tvalid    (m_tvalid[i]),
            .m_tready    (m_tready[i]),
            .enable      (enable[i]),
            .mode        (mode[i]),
            .delay       (delay[i*DELAY_WIDTH +: DELAY_WIDTH]),
            .pkt_per_gap (pkt_per_gap[i*PKT_WIDTH +: PKT_WIDTH]),
            .active      (active[i])
        );
    end

endmodule

// File: tb/tb_axis_gap_ctrl.sv
// Directed bench for axis_gap_ctrl: per-cycle gate/active expectations queued and popped.
module tb_axis_gap_ctrl;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 9;
    localparam int unsigned PW  = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [NCH-1:0]     s_tvalid, s_tlast, s_tready, m_tvalid, m_tready;
    logic [NCH-1:0]     enable, mode, active;
    logic [NCH*DW-1:0]  delay;
    logic [NCH*PW-1:0]  pkt_per_gap;
    logic [7:0]         rseq;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string tag;
        int    ch;
        bit    act;
        bit    opn;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    axis_gap_ctrl #(
        .NUM_CH      (NCH),
        .DELAY_WIDTH (DW),
        .PKT_WIDTH   (PW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_tvalid    (s_tvalid),
        .s_tlast     (s_tlast),
        .s_tready    (s_tready),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .enable      (enable),
        .mode        (mode),
        .delay       (delay),
        .pkt_per_gap (pkt_per_gap),
        .active      (active)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_win(input string tag, input int ch, input bit act, input bit opn, input int n);
        exp_t e;
        e.tag = tag;
        e.ch  = ch;
        e.act = act;
        e.opn = opn;
        for (int k = 0; k < n; k++) sb.push_back(e);
    endtask

    task automatic cmp(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_next();
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL sb_underflow: observed empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            cmp({e.tag, "/active"},   active[e.ch],   e.act);
            cmp({e.tag, "/s_tready"}, s_tready[e.ch], m_tready[e.ch] & e.opn);
            cmp({e.tag, "/m_tvalid"}, m_tvalid[e.ch], s_tvalid[e.ch] & e.opn);
        end
    endtask

    task automatic settle_check(input int n);
        #1;
        for (int k = 0; k < n; k++) check_next();
    endtask

    task automatic set_cfg(input int ch, input logic md, input int dly, input int n);
        mode[ch] = md;
        delay[ch*DW +: DW] = DW'(dly);
        pkt_per_gap[ch*PW +: PW] = PW'(n);
    endtask

    task automatic clear();
        s_tvalid = '0;
        s_tlast  = '0;
        enable   = '0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; s_tvalid = '0; s_tlast = '0; m_tready = '1;
        enable = '0; mode = '0; delay = '0; pkt_per_gap = '0; rseq = 8'b1111_0101;

        // Reset: gate transparent and inactive, both while held and after release
        cyc();
        s_tvalid = 4'b1010;
        for (int c = 0; c < 4; c++) expect_win("reset_hold", c, 1'b0, 1'b1, 1);
        settle_check(4);
        cyc();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) expect_win("post_reset", c, 1'b0, 1'b1, 1);
        settle_check(4);
        s_tvalid = '0;
        cyc();

        // Mode 0, delay 5, N=1, two-beat packet; delay changed mid-gap must not matter
        set_cfg(0, 1'b0, 5, 1); enable = 4'b0001;
        s_tvalid[0] = 1'b1; s_tlast[0] = 1'b0;
        expect_win("t1_beat0", 0, 1'b0, 1'b1, 1);
        expect_win("t1_tlast", 0, 1'b0, 1'b1, 1);
        expect_win("t1_gap",   0, 1'b1, 1'b0, 5);
        expect_win("t1_reopen",0, 1'b0, 1'b1, 1);
        settle_check(1); cyc();
        s_tlast[0] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 1) delay[0 +: DW] = DW'(1);
            settle_check(1); cyc();
        end
        clear();

        // Mode 0, delay 3, N=3, back-to-back single-beat packets
        set_cfg(0, 1'b0, 3, 3); enable = 4'b0001;
        s_tvalid[0] = 1'b1; s_tlast[0] = 1'b1;
        expect_win("t2_pkt",  0, 1'b0, 1'b1, 3);
        expect_win("t2_gap",  0, 1'b1, 1'b0, 3);
        expect_win("t2_pkt4", 0, 1'b0, 1'b1, 1);
        repeat (7) begin settle_check(1); cyc(); end
        clear();

        // Mode 1, delay 4, ready falls mid-packet; second fall inside the gap is ignored
        set_cfg(0, 1'b1, 4, 0); enable = 4'b0001;
        s_tvalid[0] = 1'b1; s_tlast[0] = 1'b0;
        expect_win("t3_beat",  0, 1'b0, 1'b1, 1);
        expect_win("t3_fall",  0, 1'b0, 1'b1, 1);
        expect_win("t3_gap",   0, 1'b1, 1'b0, 4);
        expect_win("t3_after", 0, 1'b0, 1'b1, 2);
        for (int i = 0; i < 8; i++) begin
            m_tready[0] = rseq[i];
            settle_check(1); cyc();
        end
        m_tready = '1;
        clear();

        // delay 0 in both modes: triggers never close the gate
        set_cfg(0, 1'b0, 0, 1); set_cfg(1, 1'b1, 0, 1); enable = 4'b0011;
        s_tvalid = 4'b0011; s_tlast = 4'b0011;
        for (int i = 0; i < 6; i++) begin
            m_tready[1] = ((i % 2) == 0);
            expect_win("t4_ch0", 0, 1'b0, 1'b1, 1);
            expect_win("t4_ch1", 1, 1'b0, 1'b1, 1);
            settle_check(2); cyc();
        end
        m_tready = '1;
        clear();

        // Simultaneous gaps on ch0/ch1; enable[0] dropped mid-gap leaves ch1 alone
        set_cfg(0, 1'b0, 6, 1); set_cfg(1, 1'b0, 6, 1); enable = 4'b0011;
        s_tvalid = 4'b0011; s_tlast = 4'b0011;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) enable[0] = 1'b0;
            expect_win("t5_ch0", 0, (i == 1 || i == 2), !(i == 1 || i == 2), 1);
            expect_win("t5_ch1", 1, (i >= 1 && i <= 6), !(i >= 1 && i <= 6), 1);
            settle_check(2); cyc();
        end
        clear();

        // Reset during a 200-cycle gap; packet count must restart from zero afterwards
        set_cfg(0, 1'b0, 200, 2); enable = 4'b0001; m_tready = '1;
        s_tvalid[0] = 1'b1; s_tlast[0] = 1'b1;
        expect_win("t6_pkt1", 0, 1'b0, 1'b1, 1);
        settle_check(1); cyc();
        s_tvalid[0] = 1'b0; mode[0] = 1'b1; m_tready[0] = 1'b0;
        expect_win("t6_fall", 0, 1'b0, 1'b1, 1);
        settle_check(1); cyc();
        s_tvalid[0] = 1'b1; m_tready[0] = 1'b1;
        expect_win("t6_gap", 0, 1'b1, 1'b0, 3);
        repeat (2) begin settle_check(1); cyc(); end
        reset = 1'b1;
        settle_check(1); cyc();
        reset = 1'b0; mode[0] = 1'b0; delay[0 +: DW] = DW'(2);
        expect_win("t6_after_rst", 0, 1'b0, 1'b1, 2);
        expect_win("t6_gap2",      0, 1'b1, 1'b0, 2);
        expect_win("t6_reopen",    0, 1'b0, 1'b1, 1);
        repeat (5) begin settle_check(1); cyc(); end
        clear();

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d leftover expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
